// File: rtl/lsm_sequencer.sv
// Load/store-multiple sequencer: walks a register mask and moves each selected
// register to or from consecutive memory words, one access at a time.
module lsm_sequencer #(
    parameter  int NREG = 8,
    parameter  int AW   = 16,
    parameter  int DW   = 16,
    localparam int RW   = $clog2(NREG),
    localparam int CW   = $clog2(NREG + 1)
) (
    input  logic            clk,
    input  logic            proc_rst,
    input  logic            start,
    input  logic            mode,
    input  logic            dir,
    input  logic [NREG-1:0] reg_mask,
    input  logic [AW-1:0]   base_addr,
    input  logic            mem_ready,
    input  logic [DW-1:0]   mem_rdata,
    input  logic [DW-1:0]   rf_rdata,
    output logic            busy,
    output logic            done,
    output logic            mem_read,
    output logic            mem_write,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [RW-1:0]   rf_raddr,
    output logic [RW-1:0]   rf_waddr,
    output logic            rf_wen,
    output logic [DW-1:0]   rf_wdata,
    output logic [CW-1:0]   count,
    output logic [AW-1:0]   final_addr
);

    // state  | meaning
    // IDLE   | waiting for start
    // SCAN   | pick next register index from the remaining mask
    // ACCESS | memory strobe held until mem_ready
    // DONE   | one-cycle done pulse, final_addr valid
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SCAN   = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t          state_q;
    logic [NREG-1:0] mask_q;
    logic [AW-1:0]   ptr_q;
    logic            mode_q;
    logic            dir_q;
    logic [RW-1:0]   idx_q;
    logic [AW-1:0]   addr_q;
    logic            rd_q;
    logic            wr_q;
    logic            busy_q;
    logic            done_q;
    logic [CW-1:0]   count_q;
    logic [AW-1:0]   final_q;

    logic [RW-1:0]   idx_d;
    logic [NREG-1:0] mask_d;
    logic [AW-1:0]   ptr_d;

    // dir=0 picks the lowest set bit, dir=1 the highest
    function automatic logic [RW-1:0] pick_idx(input logic [NREG-1:0] m, input logic d);
        logic [RW-1:0] r;
        r = '0;
        if (!d) begin
            for (int i = NREG - 1; i >= 0; i--)
                if (m[i]) r = RW'(i);
        end else begin
            for (int i = 0; i < NREG; i++)
                if (m[i]) r = RW'(i);
        end
        return r;
    endfunction

    always_comb begin
        idx_d  = pick_idx(mask_q, dir_q);
        mask_d = mask_q & ~(NREG'(1) << idx_q);
        ptr_d  = dir_q ? (ptr_q - AW'(1)) : (ptr_q + AW'(1));
    end

    always_ff @(posedge clk) begin
        if (proc_rst) begin
            state_q <= S_IDLE;
            mask_q  <= '0;
            ptr_q   <= '0;
            mode_q  <= 1'b0;
            dir_q   <= 1'b0;
            idx_q   <= '0;
            addr_q  <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
            final_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mask_q  <= reg_mask;
                        ptr_q   <= base_addr;
                        mode_q  <= mode;
                        dir_q   <= dir;
                        count_q <= '0;
                        busy_q  <= 1'b1;
                        if (reg_mask == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            final_q <= base_addr;
                        end else begin
                            state_q <= S_SCAN;
                            final_q <= '0;
                        end
                    end
                end
                S_SCAN: begin
                    idx_q   <= idx_d;
                    addr_q  <= ptr_q;
                    rd_q    <= ~mode_q;
                    wr_q    <= mode_q;
                    state_q <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (mem_ready) begin
                        mask_q  <= mask_d;
                        ptr_q   <= ptr_d;
                        count_q <= count_q + CW'(1);
                        rd_q    <= 1'b0;
                        wr_q    <= 1'b0;
                        if (mask_d == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            final_q <= ptr_d;
                        end else begin
                            state_q <= S_SCAN;
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign mem_read   = rd_q;
    assign mem_write  = wr_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = rf_rdata;
    assign rf_raddr   = idx_q;
    assign rf_waddr   = idx_q;
    // gated by reset so a completing load cannot write during the reset cycle
    assign rf_wen     = rd_q & mem_ready & ~proc_rst;
    assign rf_wdata   = mem_rdata;
    assign count      = count_q;
    assign final_addr = final_q;

endmodule
